frame_minmax_tracker: RTL and testbench

Streaming reduction stage downstream of `eight_bit_comparator`: accepts a frame of unsigned 8-bit samples over a valid/ready handshake and reports the frame's maximum and minimum, the index of each, and the number of samples equal to the maximum. All magnitude decisions come from two instances of `eight_bit_comparator`, using its Greater/Less/Equal flags. Results are held on a valid/ready output until they are consumed.

---
 rtl/minmax_pkg.sv | 21 ++
 rtl/eight_bit_comparator.sv | 14 +
 rtl/frame_minmax_tracker.sv | 139 +++++++++++++
 tb/tb_frame_minmax_tracker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared widths, FSM state encoding and result payload for the frame min/max tracker.
package minmax_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] max_val;
        logic [DATA_W-1:0] min_val;
        logic [IDX_W-1:0]  max_idx;
        logic [IDX_W-1:0]  min_idx;
        logic [IDX_W-1:0]  max_cnt;
    } result_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator; exactly one of Greater/Less/Equal is high.
module eight_bit_comparator (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       Greater,
    output logic       Less,
    output logic       Equal
);

    assign Greater = (A > B);
    assign Less    = (A < B);
    assign Equal   = (A == B);

endmodule

// File: rtl/frame_minmax_tracker.sv
// Reduces a frame of FRAME_LEN unsigned samples to max/min, their first indices and the
// count of maximum hits; the result is held on a valid/ready output until consumed.
module frame_minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_max_idx,
    output logic [IDX_W-1:0]  out_min_idx,
    output logic [IDX_W-1:0]  out_max_cnt
);

    state_t           r_state, w_state_nxt;
    result_t          r_acc, w_acc_nxt;
    result_t          r_res, w_res_nxt;
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] w_cnt_inc;
    logic             r_in_ready, r_out_valid;

    logic w_max_gt, w_max_lt, w_max_eq;
    logic w_min_gt, w_min_lt, w_min_eq;

    eight_bit_comparator U_MAX (
        .A       (in_data),
        .B       (r_acc.max_val),
        .Greater (w_max_gt),
        .Less    (w_max_lt),
        .Equal   (w_max_eq)
    );

    eight_bit_comparator U_MIN (
        .A       (in_data),
        .B       (r_acc.min_val),
        .Greater (w_min_gt),
        .Less    (w_min_lt),
        .Equal   (w_min_eq)
    );

    assign w_cnt_inc = r_cnt + IDX_W'(1);

    // Next-state, working accumulator and published result
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;

        if (clear) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_res_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_acc_nxt.max_val = in_data;
                        w_acc_nxt.min_val = in_data;
                        w_acc_nxt.max_idx = '0;
                        w_acc_nxt.min_idx = '0;
                        w_acc_nxt.max_cnt = IDX_W'(1);
                        w_cnt_nxt         = IDX_W'(1);
                        w_state_nxt       = ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        case ({w_max_gt, w_max_eq, w_max_lt})
                            3'b100: begin
                                w_acc_nxt.max_val = in_data;
                                w_acc_nxt.max_idx = r_cnt;
                                w_acc_nxt.max_cnt = IDX_W'(1);
                            end
                            3'b010:  w_acc_nxt.max_cnt = r_acc.max_cnt + IDX_W'(1);
                            default: ;
                        endcase
                        case ({w_min_gt, w_min_eq, w_min_lt})
                            3'b001: begin
                                w_acc_nxt.min_val = in_data;
                                w_acc_nxt.min_idx = r_cnt;
                            end
                            default: ;
                        endcase
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == IDX_W'(FRAME_LEN)) begin
                            w_res_nxt   = w_acc_nxt;
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Handshake flags are registered from the next state so they track r_state exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_res       <= w_res_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= (w_state_nxt != HOLD);
            r_out_valid <= (w_state_nxt == HOLD);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_max     = r_res.max_val;
    assign out_min     = r_res.min_val;
    assign out_max_idx = r_res.max_idx;
    assign out_min_idx = r_res.min_idx;
    assign out_max_cnt = r_res.max_cnt;

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Scoreboard bench for frame_minmax_tracker: expected results queued per frame, popped on handshake.
module tb_frame_minmax_tracker;

    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_max, out_min, out_max_idx, out_min_idx, out_max_cnt;

    typedef struct {
        int mx;
        int mn;
        int mxi;
        int mni;
        int mxc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   hs_cyc[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    int f_basic[FL] = '{100, 50, 32, 255, 0, 31, 26, 99};
    int f_equal[FL] = '{6, 6, 6, 6, 6, 6, 6, 6};
    int f_ties[FL]  = '{10, 16, 16, 10, 11, 16, 10, 12};
    int f_bp2[FL]   = '{235, 200, 36, 66, 76, 86, 56, 26};
    int f_rnd[FL];

    frame_minmax_tracker #(.FRAME_LEN(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_idx (out_max_idx),
        .out_min_idx (out_min_idx),
        .out_max_cnt (out_max_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int f[FL]);
        exp_t e;
        e.mx = f[0]; e.mn = f[0]; e.mxi = 0; e.mni = 0; e.mxc = 1;
        for (int i = 1; i < FL; i++) begin
            if (f[i] > e.mx) begin
                e.mx = f[i]; e.mxi = i; e.mxc = 1;
            end else if (f[i] == e.mx) begin
                e.mxc++;
            end
            if (f[i] < e.mn) begin
                e.mn = f[i]; e.mni = i;
            end
        end
        return e;
    endfunction

    // Output side: compare against the scoreboard on each handshake
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                m_e = sb.pop_front();
                chk("max",     int'(out_max),     m_e.mx);
                chk("min",     int'(out_min),     m_e.mn);
                chk("max_idx", int'(out_max_idx), m_e.mxi);
                chk("min_idx", int'(out_min_idx), m_e.mni);
                chk("max_cnt", int'(out_max_cnt), m_e.mxc);
            end
        end
    end

    task automatic send(input int d, input int gap);
        bit acc;
        bit done;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = 8'(d);
        done = 1'b0;
        for (int t = 0; t < 50; t++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int f[FL], input int maxgap, input bit push);
        for (int i = 0; i < FL; i++)
            send(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        if (push) sb.push_back(model(f));
    endtask

    task automatic rand_frame();
        for (int i = 0; i < FL; i++) f_rnd[i] = int'($urandom_range(0, 255));
    endtask

    task automatic chk_zero_outs(input string pfx);
        chk({pfx, "_ready"},   int'(in_ready),    1);
        chk({pfx, "_valid"},   int'(out_valid),   0);
        chk({pfx, "_max"},     int'(out_max),     0);
        chk({pfx, "_min"},     int'(out_min),     0);
        chk({pfx, "_max_idx"}, int'(out_max_idx), 0);
        chk({pfx, "_min_idx"}, int'(out_min_idx), 0);
        chk({pfx, "_max_cnt"}, int'(out_max_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk_zero_outs("por");
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back frames with out_ready held high
        hs_cyc.delete();
        send_frame(f_basic, 0, 1);
        send_frame(f_equal, 0, 1);
        send_frame(f_ties, 0, 1);
        repeat (2) @(posedge clk); #1;
        chk("hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            chk("period_1", hs_cyc[1] - hs_cyc[0], FL + 1);
            chk("period_2", hs_cyc[2] - hs_cyc[1], FL + 1);
        end
        chk("post_valid", int'(out_valid), 0);

        // Backpressure with junk input while holding
        out_ready = 1'b0;
        send_frame(f_basic, 0, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("bp_ready", int'(in_ready),  0);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_max",   int'(out_max),   255);
            chk("bp_min",   int'(out_min),   0);
            chk("bp_midx",  int'(out_max_idx), 3);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_frame(f_bp2, 0, 1);
        repeat (3) @(posedge clk); #1;

        // Bubbles, then clear while a sample is offered
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        in_valid = 1'b1;
        in_data  = 8'd7;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_ready", int'(in_ready),  1);
        chk("clr_max",   int'(out_max),   0);
        chk("clr_cnt",   int'(out_max_cnt), 0);
        rand_frame();
        send_frame(f_rnd, 3, 1);
        repeat (3) @(posedge clk); #1;

        // Async reset mid-frame
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)), 0);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk_zero_outs("rst_mid");
        #1;
        reset = 1'b0;
        rand_frame();
        send_frame(f_rnd, 1, 1);
        repeat (3) @(posedge clk); #1;

        // Async reset while holding a result
        out_ready = 1'b0;
        rand_frame();
        send_frame(f_rnd, 0, 0);
        @(negedge clk);
        chk("hold_valid", int'(out_valid), 1);
        #1;
        reset = 1'b1;
        #1;
        chk_zero_outs("rst_hold");
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        rand_frame();
        send_frame(f_rnd, 0, 1);

        repeat (5) @(posedge clk); #1;
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
